// File: rtl/resource_pool_lock_pkg.sv
// Shared types and helpers for the resource pool lock.
// Age compare lives here so issue and commit reuse it.
package resource_pool_lock_pkg;

  localparam int RPL_ID_W = 4;

  // Per-requester bundle; packs as {req, id, release}.
  typedef struct packed {
    logic                req;
    logic [RPL_ID_W-1:0] req_issue_id;
    logic                release_lock;
  } rpl_req_t;

  // Bit offsets of the fields inside one packed slot.
  localparam int RPL_REL_BIT = 0;
  localparam int RPL_ID_LSB  = 1;

  // Index width, never below one bit.
  function automatic int unsigned idx_w(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // a older than b: (a - b) mod 2^w read as signed < 0.
  function automatic logic id_older(
    input logic [31:0] a,
    input logic [31:0] b,
    input int unsigned w
  );
    logic [31:0] d;
    d = (a - b) << (32 - w);
    return d[31];
  endfunction

endpackage

// File: rtl/resource_pool_lock_oldest_select.sv
// Combinational oldest-eligible picker.
// Ties go to the lowest requester index.
module rpl_oldest_select
  import resource_pool_lock_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 4,
  parameter int IW       = 2
) (
  input  logic [NUM_REQ-1:0]               eligible,
  input  logic [NUM_REQ-1:0][ID_WIDTH-1:0] issue_id,
  output logic                             win_valid,
  output logic [IW-1:0]                    win_idx
);

  logic [ID_WIDTH-1:0] best_id;

  // Scan upward; replace only on strictly older.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    best_id   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (eligible[i] &&
          (!win_valid ||
           id_older(32'(issue_id[i]),
                    32'(best_id),
                    ID_WIDTH))) begin
        win_valid = 1'b1;
        win_idx   = IW'(i);
        best_id   = issue_id[i];
      end
    end
  end

endmodule

// File: rtl/resource_pool_lock.sv
// Pool of identical units locked by age-ordered requesters.
// State is one {busy, owner} register per unit.
module resource_pool_lock
  import resource_pool_lock_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int NUM_RES  = 2,
  parameter  int ID_WIDTH = 4,
  localparam int UW = idx_w(NUM_RES),
  localparam int RW = idx_w(NUM_REQ),
  localparam int FW = $clog2(NUM_RES + 1),
  localparam int SW = ID_WIDTH + 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0][SW-1:0]   rpl_in,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0][UW-1:0]   grant_unit,
  output logic [NUM_RES-1:0]           unit_busy,
  output logic [NUM_RES-1:0][RW-1:0]   unit_owner,
  output logic [FW-1:0]                free_count
);

  logic [NUM_RES-1:0]         busy_q;
  logic [NUM_RES-1:0]         busy_d;
  logic [NUM_RES-1:0][RW-1:0] owner_q;
  logic [NUM_RES-1:0][RW-1:0] owner_d;

  logic [NUM_REQ-1:0]               req;
  logic [NUM_REQ-1:0]               rel;
  logic [NUM_REQ-1:0][ID_WIDTH-1:0] ids;
  logic [NUM_REQ-1:0]               owns;
  logic [NUM_REQ-1:0]               elig;

  logic          free_any;
  logic [UW-1:0] free_idx;
  logic          win_valid;
  logic [RW-1:0] win_idx;

  // Unpack requests and derive eligibility.
  always_comb begin
    req  = '0;
    rel  = '0;
    ids  = '0;
    owns = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i] = rpl_in[i][SW-1];
      rel[i] = rpl_in[i][RPL_REL_BIT];
      ids[i] = rpl_in[i][RPL_ID_LSB +: ID_WIDTH];
      for (int u = 0; u < NUM_RES; u++) begin
        if (busy_q[u] && owner_q[u] == RW'(i)) begin
          owns[i] = 1'b1;
        end
      end
    end
    elig = req & ~owns & ~rel;
  end

  // Lowest-index unit free at cycle start.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int u = NUM_RES - 1; u >= 0; u--) begin
      if (!busy_q[u]) begin
        free_any = 1'b1;
        free_idx = UW'(u);
      end
    end
  end

  rpl_oldest_select #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH),
    .IW       (RW)
  ) u_sel (
    .eligible  (elig),
    .issue_id  (ids),
    .win_valid (win_valid),
    .win_idx   (win_idx)
  );

  // Releases clear units; a freed unit waits a cycle.
  always_comb begin
    busy_d  = busy_q;
    owner_d = owner_q;
    for (int u = 0; u < NUM_RES; u++) begin
      if (busy_q[u] && rel[owner_q[u]]) begin
        busy_d[u] = 1'b0;
      end
    end
    if (free_any && win_valid) begin
      busy_d[free_idx]  = 1'b1;
      owner_d[free_idx] = win_idx;
    end
  end

  // Owner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      owner_q <= '0;
    end else begin
      busy_q  <= busy_d;
      owner_q <= owner_d;
    end
  end

  // Outputs decoded from owner registers only.
  always_comb begin
    grant      = '0;
    grant_unit = '0;
    free_count = FW'(NUM_RES);
    for (int u = 0; u < NUM_RES; u++) begin
      if (busy_q[u]) begin
        grant[owner_q[u]]      = 1'b1;
        grant_unit[owner_q[u]] = UW'(u);
        free_count = free_count - FW'(1);
      end
    end
  end

  assign unit_busy  = busy_q;
  assign unit_owner = owner_q;

endmodule

// File: tb/tb_resource_pool_lock.sv
// Directed bench for resource_pool_lock.
// Default sizes: 4 requesters, 2 units, 4-bit ids.
module tb_resource_pool_lock;
  import resource_pool_lock_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  rpl_req_t             r [4];
  logic [3:0][5:0]      rpl_in;
  logic [3:0]           grant;
  logic [3:0][0:0]      grant_unit;
  logic [1:0]           unit_busy;
  logic [1:0][1:0]      unit_owner;
  logic [1:0]           free_count;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    rpl_in = '0;
    for (int i = 0; i < 4; i++) rpl_in[i] = r[i];
  end

  resource_pool_lock dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rpl_in     (rpl_in),
    .grant      (grant),
    .grant_unit (grant_unit),
    .unit_busy  (unit_busy),
    .unit_owner (unit_owner),
    .free_count (free_count)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_r(
    input int         i,
    input logic       rq,
    input logic [3:0] id,
    input logic       rl
  );
    r[i].req          = rq;
    r[i].req_issue_id = id;
    r[i].release_lock = rl;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) set_r(i, 0, 0, 0);
    #12;
    check("rst_grant", 32'(grant), 0);
    check("rst_gu", 32'(grant_unit), 0);
    check("rst_busy", 32'(unit_busy), 0);
    check("rst_owner", 32'(unit_owner), 0);
    check("rst_free", 32'(free_count), 2);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single request
    set_r(0, 1, 3, 0);
    step();
    check("single_grant", 32'(grant), 4'b0001);
    check("single_gu0", 32'(grant_unit[0]), 0);
    check("single_free", 32'(free_count), 1);
    check("single_busy", 32'(unit_busy), 2'b01);
    set_r(0, 0, 3, 1);
    step();
    check("rel_grant", 32'(grant), 0);
    check("rel_free", 32'(free_count), 2);
    set_r(0, 0, 0, 0);

    // age order
    set_r(1, 1, 5, 0);
    set_r(2, 1, 4, 0);
    step();
    check("age_c2_grant", 32'(grant), 4'b0100);
    check("age_c2_gu2", 32'(grant_unit[2]), 0);
    check("age_c2_free", 32'(free_count), 1);
    step();
    check("age_c3_grant", 32'(grant), 4'b0110);
    check("age_c3_gu1", 32'(grant_unit[1]), 1);
    check("age_c3_own1", 32'(unit_owner[1]), 1);
    check("age_c3_own0", 32'(unit_owner[0]), 2);
    check("age_c3_free", 32'(free_count), 0);

    // abort release by a non-owner, pool full
    set_r(0, 0, 0, 1);
    step();
    check("abort_grant", 32'(grant), 4'b0110);
    check("abort_busy", 32'(unit_busy), 2'b11);
    set_r(0, 0, 0, 0);

    // two releases in one cycle
    set_r(1, 0, 5, 1);
    set_r(2, 0, 4, 1);
    step();
    check("mrel_grant", 32'(grant), 0);
    check("mrel_busy", 32'(unit_busy), 0);
    check("mrel_free", 32'(free_count), 2);
    set_r(1, 0, 0, 0);
    set_r(2, 0, 0, 0);

    // wrap-around: 14 older than 1
    set_r(0, 1, 14, 0);
    set_r(1, 1, 1, 0);
    step();
    check("wrap_c2_grant", 32'(grant), 4'b0001);
    step();
    check("wrap_c3_grant", 32'(grant), 4'b0011);
    check("wrap_c3_gu1", 32'(grant_unit[1]), 1);
    set_r(0, 0, 14, 1);
    set_r(1, 0, 1, 1);
    step();
    check("wrap_rel", 32'(grant), 0);
    set_r(0, 0, 0, 0);
    set_r(1, 0, 0, 0);

    // equal ids: lower index wins
    set_r(1, 1, 7, 0);
    set_r(2, 1, 7, 0);
    step();
    check("tie_grant", 32'(grant), 4'b0010);
    set_r(1, 0, 7, 1);
    set_r(2, 0, 7, 1);
    step();
    check("tie_rel", 32'(grant), 0);
    set_r(1, 0, 0, 0);
    set_r(2, 0, 0, 0);

    // hold through req drop, release, delayed reuse
    set_r(0, 1, 2, 0);
    set_r(1, 1, 3, 0);
    step();
    check("hold_a", 32'(grant), 4'b0001);
    step();
    check("hold_b", 32'(grant), 4'b0011);
    set_r(3, 1, 1, 0);
    step();
    check("hold_full", 32'(grant), 4'b0011);
    set_r(0, 0, 2, 0);
    step();
    check("hold_drop", 32'(grant), 4'b0011);
    set_r(0, 0, 2, 1);
    step();
    check("hold_rel", 32'(grant), 4'b0010);
    check("hold_rel_free", 32'(free_count), 1);
    set_r(0, 0, 0, 0);
    step();
    check("reuse_grant", 32'(grant), 4'b1010);
    check("reuse_gu3", 32'(grant_unit[3]), 0);
    check("reuse_own0", 32'(unit_owner[0]), 3);

    // reset mid-ownership
    set_r(0, 1, 0, 0);
    set_r(1, 0, 0, 0);
    set_r(3, 0, 0, 0);
    step();
    check("pre_rst", 32'(grant), 4'b1010);
    rst_n = 1'b0;
    #1;
    check("arst_grant", 32'(grant), 0);
    check("arst_free", 32'(free_count), 2);
    check("arst_busy", 32'(unit_busy), 0);
    step();
    check("rst_hold", 32'(grant), 0);
    rst_n = 1'b1;
    step();
    check("post_rst", 32'(grant), 4'b0001);
    check("post_rst_gu", 32'(grant_unit[0]), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
